// File: rtl/regfile_param_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_if
// Brief    : Read/write/stack bus between the CPU core and its register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sp_push;
    logic              sp_pop;
    logic [DATA_W-1:0] initial_input;
    logic [DATA_W-1:0] result_reg;
    logic [DATA_W-1:0] sp_value;
    logic              busy;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
               sp_push, sp_pop, initial_input,
        input  rd_data1, rd_data2, result_reg, sp_value, busy
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
               sp_push, sp_pop, initial_input,
        output rd_data1, rd_data2, result_reg, sp_value, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Brief    : Parametrised register file with bypassed read ports, zero register,
//            stack-pointer push/pop and a post-reset clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 4,
    parameter int                RESULT_REG = 0,
    parameter int                ZERO_REG   = 1,
    parameter int                SP_REG     = 14,
    parameter int                INPUT_REG  = 12,
    parameter logic [DATA_W-1:0] SP_INIT    = 16'hFFFE,
    parameter int                SP_STEP    = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    regfile_param_if.slave        bus
);
    localparam int                NUM_REGS   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero     = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] c_sp       = ADDR_W'(SP_REG);
    localparam logic [ADDR_W-1:0] c_in       = ADDR_W'(INPUT_REG);
    localparam logic [ADDR_W-1:0] c_res      = ADDR_W'(RESULT_REG);
    localparam logic [ADDR_W-1:0] c_cnt_last = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] c_step     = DATA_W'(SP_STEP);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              w_busy;
    logic              w_wr_ok;
    logic              w_sp_written;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;

    assign w_busy       = (r_state == S_CLEAR);
    assign w_wr_ok      = bus.wr_en && (bus.wr_addr != c_zero);
    assign w_sp_written = w_wr_ok && (bus.wr_addr == c_sp);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Only the three architecturally defined registers are touched by reset;
    // the sweep then clears everything else except SP and the input register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_regs[c_sp]   <= SP_INIT;
            r_regs[c_in]   <= bus.initial_input;
            r_regs[c_zero] <= '0;
        end else if (w_busy) begin
            if ((r_cnt != c_sp) && (r_cnt != c_in)) begin
                r_regs[r_cnt] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_regs[bus.wr_addr] <= bus.wr_data;
            end
            if (!w_sp_written && (bus.sp_push != bus.sp_pop)) begin
                r_regs[c_sp] <= bus.sp_pop ? (r_regs[c_sp] + c_step)
                                           : (r_regs[c_sp] - c_step);
            end
        end
    end

    always_comb begin
        w_rd_data1 = '0;
        w_rd_data2 = '0;
        if (!w_busy) begin
            if (w_wr_ok && (bus.wr_addr == bus.rd_addr1)) begin
                w_rd_data1 = bus.wr_data;
            end else if (bus.rd_addr1 != c_zero) begin
                w_rd_data1 = r_regs[bus.rd_addr1];
            end
            if (w_wr_ok && (bus.wr_addr == bus.rd_addr2)) begin
                w_rd_data2 = bus.wr_data;
            end else if (bus.rd_addr2 != c_zero) begin
                w_rd_data2 = r_regs[bus.rd_addr2];
            end
        end
    end

    assign bus.rd_data1   = w_rd_data1;
    assign bus.rd_data2   = w_rd_data2;
    assign bus.result_reg = w_busy ? '0 : r_regs[c_res];
    assign bus.sp_value   = w_busy ? SP_INIT : r_regs[c_sp];
    assign bus.busy       = w_busy;

endmodule
`default_nettype wire

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised general-purpose register file for the 16-bit CPU datapath; next generation of the core register bank.
- Two combinational read ports with write-through bypass, one write port, and a hardwired zero register.
- Adds dedicated stack-pointer push/pop increment logic and a post-reset clear-sweep state machine, so every register holds a defined value before the core issues instructions.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W
RESULT_REG, 0, index driven onto result_reg
ZERO_REG, 1, hardwired-zero index; reads 0, writes dropped
SP_REG, 14, stack-pointer index
INPUT_REG, 12, index loaded with initial_input at reset
SP_INIT, 16'hFFFE, stack-pointer reset value (DATA_W wide)
SP_STEP, 2, push/pop decrement/increment amount

Ports:
clk  in  1  clock; all state updates on posedge
reset_n  in  1  synchronous, active-low reset
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data, combinational
rd_data2  out  DATA_W  read port 2 data, combinational
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
sp_push  in  1  SP <= SP - SP_STEP
sp_pop  in  1  SP <= SP + SP_STEP
initial_input  in  DATA_W  value loaded into INPUT_REG at reset
result_reg  out  DATA_W  contents of RESULT_REG (registered storage, no bypass)
sp_value  out  DATA_W  contents of SP_REG (registered storage)
busy  out  1  high while the clear sweep runs

Behaviour:
- Reset: reset_n sampled low at posedge loads SP_REG=SP_INIT, INPUT_REG=initial_input, ZERO_REG=0.
  - FSM goes to CLEAR with sweep counter=0; busy=1 from the following cycle.
  - Other registers are unchanged by reset itself.
- FSM states are CLEAR and RUN.
- CLEAR state:
  - Each posedge writes 0 to register[counter], except SP_REG and INPUT_REG, which are skipped and keep their reset values.
  - Counter increments by 1 each cycle. Sweep lasts exactly NUM_REGS cycles.
  - When counter == NUM_REGS-1, that final write occurs and the FSM enters RUN; busy=0 on the next cycle.
- Outputs while busy:
  - rd_data1/rd_data2 = 0 for every address.
  - result_reg = 0 and sp_value = SP_INIT.
  - wr_en, sp_push and sp_pop are ignored.
- RUN state:
  - wr_en=1 and wr_addr != ZERO_REG: register[wr_addr] <= wr_data at posedge.
  - Write to ZERO_REG is dropped; ZERO_REG always reads 0.
- Read path:
  - rd_dataN = register[rd_addrN].
  - Bypass: if not busy, wr_en=1, wr_addr==rd_addrN and wr_addr != ZERO_REG, then rd_dataN = wr_data in the same cycle.
  - Push/pop updates are not bypassed; reads of SP_REG show the stored value until the next edge.
- Stack pointer:
  - push alone: SP - SP_STEP. pop alone: SP + SP_STEP. Arithmetic is modulo 2**DATA_W, so 0x0000 push -> 0xFFFE and 0xFFFE pop -> 0x0000.
  - push and pop together: SP unchanged.
  - wr_en to SP_REG in the same cycle as push/pop: wr_en wins, push/pop discarded.
- Reset priority: reset_n low overrides all activity in any state, including mid-sweep; the sweep restarts from counter 0.
- result_reg and sp_value update one cycle after the writing edge (storage view).

Test Plan:
- Reset with initial_input=16'h1234, release, count cycles: busy high exactly 16 cycles; afterwards r12=16'h1234, r14=16'hFFFE, all others 0; reads during busy return 0.
- After sweep, write r3=16'hBEEF with rd_addr1=3 in the same cycle: rd_data1=16'hBEEF combinationally (bypass); next cycle stored value 16'hBEEF; write r1=16'h5555 -> r1 still reads 0, no bypass.
- Push twice from 16'hFFFE: sp_value 16'hFFFC then 16'hFFFA. Push+pop together: unchanged. Push from 16'h0000: 16'hFFFE. Pop from 16'hFFFE: 16'h0000.
- wr_en to r14 with data 16'h0100 while sp_push=1: sp_value=16'h0100.
- Assert reset_n low on cycle 7 of the sweep, release: busy high a full 16 cycles again; r12 reloads the new initial_input.
- Drive wr_en (r5=16'hAAAA) and sp_push during busy: after sweep r5=0, sp_value=16'hFFFE.
